// File: rtl/curve_rhs.sv
// curve_rhs
//   Evaluates the short Weierstrass right-hand side rhs = x^3 + A*x + B mod P,
//   and rhs^2 mod P. Both results feed a downstream modular square root.
//   All products come from one shared serial modular multiplier (mod_mul).
//
//   Build option: define CURVE_RHS_A_TERM_EN to include the A*x term.
//   When it is not defined, A is ignored and the Mul_ax/Add_ax steps are
//   skipped.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle request, sampled only in Idle
//   x            x-coordinate, captured on an accepted start
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse, results valid
//   rhs          x^3 + A*x + B mod P
//   rhs_squared  rhs^2 mod P
//   x_invalid    x >= P for the last request
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for start, x captured on start
// LOAD    | range check of x against P
// MUL_X2  | x2 = x*x
// MUL_X3  | x3 = x2*x
// MUL_AX  | ax = A*x            (CURVE_RHS_A_TERM_EN only)
// ADD_AX  | t = x3 + ax mod P   (CURVE_RHS_A_TERM_EN only)
// ADD_B   | rhs = t + B mod P
// MUL_SQ  | rhs_squared = rhs*rhs
// FINISH  | done pulse, back to IDLE

module mod_mul #(
  parameter logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         done,
  output logic [255:0] product
);
  // MSB-first double-and-add over the bits of b, one bit per cycle.
  // Operands must be below P and held stable while rst is low.
  // rst is sampled synchronously; done stays high until the next rst.
  logic [255:0] acc;
  logic [255:0] b_sh;
  logic [8:0]   cnt;
  logic [256:0] dbl;
  logic [256:0] sum;

  always_comb begin
    dbl = {acc, 1'b0};
    if (dbl >= {1'b0, P}) dbl = dbl - {1'b0, P};
    sum = dbl + (b_sh[255] ? {1'b0, a} : 257'd0);
    if (sum >= {1'b0, P}) sum = sum - {1'b0, P};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      b_sh <= b;
      cnt  <= 9'd256;
      done <= 1'b0;
    end else if (cnt != 9'd0) begin
      acc  <= sum[255:0];
      b_sh <= {b_sh[254:0], 1'b0};
      cnt  <= cnt - 9'd1;
      done <= (cnt == 9'd1);
    end
  end

  assign product = acc;
endmodule

module curve_rhs #(
  parameter logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [255:0] A = 256'd0,
  parameter logic [255:0] B = 256'd7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] x,
  output logic         busy,
  output logic         done,
  output logic [255:0] rhs,
  output logic [255:0] rhs_squared,
  output logic         x_invalid
);
  typedef enum logic [3:0] {
    IDLE, LOAD, MUL_X2, MUL_X3, MUL_AX, ADD_AX, ADD_B, MUL_SQ, FINISH
  } state_t;

  state_t       state, state_next;
  logic [255:0] x_q;
  logic [255:0] x2;
  logic [255:0] x3;
`ifdef CURVE_RHS_A_TERM_EN
  logic [255:0] ax;
  logic [255:0] t;
`endif
  logic         mul_rst_q;
  logic         mul_rst;
  logic         mul_done;
  logic         mul_adv;
  logic [255:0] mul_a;
  logic [255:0] mul_b;
  logic [255:0] mul_p;

  function automatic logic [255:0] add_mod(input logic [255:0] u, input logic [255:0] v);
    logic [256:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic is_mul(input state_t s);
    return (s == MUL_X2) || (s == MUL_X3) || (s == MUL_AX) || (s == MUL_SQ);
  endfunction

  // done from the previous multiplication is still high during the reset
  // cycle of the next Mul state, so it must not count there.
  assign mul_adv = mul_done && !mul_rst_q;
  assign mul_rst = mul_rst_q || !rst_n;

  mod_mul #(.P(P)) u_mul (
    .clk     (clk),
    .rst     (mul_rst),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    state_next = state;
    mul_a      = '0;
    mul_b      = '0;
    case (state)
      IDLE:   if (start) state_next = LOAD;
      LOAD:   state_next = (x_q >= P) ? FINISH : MUL_X2;
      MUL_X2: begin
        mul_a = x_q;
        mul_b = x_q;
        if (mul_adv) state_next = MUL_X3;
      end
      MUL_X3: begin
        mul_a = x2;
        mul_b = x_q;
`ifdef CURVE_RHS_A_TERM_EN
        if (mul_adv) state_next = MUL_AX;
`else
        if (mul_adv) state_next = ADD_B;
`endif
      end
`ifdef CURVE_RHS_A_TERM_EN
      MUL_AX: begin
        mul_a = A;
        mul_b = x_q;
        if (mul_adv) state_next = ADD_AX;
      end
      ADD_AX: state_next = ADD_B;
`endif
      ADD_B:  state_next = MUL_SQ;
      MUL_SQ: begin
        mul_a = rhs;
        mul_b = rhs;
        if (mul_adv) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mul_rst_q   <= 1'b0;
      x_q         <= '0;
      x2          <= '0;
      x3          <= '0;
`ifdef CURVE_RHS_A_TERM_EN
      ax          <= '0;
      t           <= '0;
`endif
      rhs         <= '0;
      rhs_squared <= '0;
      x_invalid   <= 1'b0;
    end else begin
      state     <= state_next;
      // multiplier reset covers exactly the first cycle of each Mul state
      mul_rst_q <= is_mul(state_next) && (state_next != state);
      case (state)
        IDLE: if (start) x_q <= x;
        LOAD: begin
          if (x_q >= P) begin
            x_invalid   <= 1'b1;
            rhs         <= '0;
            rhs_squared <= '0;
          end else begin
            x_invalid   <= 1'b0;
          end
        end
        MUL_X2: if (mul_adv) x2 <= mul_p;
        MUL_X3: if (mul_adv) x3 <= mul_p;
`ifdef CURVE_RHS_A_TERM_EN
        MUL_AX: if (mul_adv) ax <= mul_p;
        ADD_AX: t <= add_mod(x3, ax);
        ADD_B:  rhs <= add_mod(t, B);
`else
        ADD_B:  rhs <= add_mod(x3, B);
`endif
        MUL_SQ: if (mul_adv) rhs_squared <= mul_p;
        default: ;
      endcase
    end
  end

  assign done = (state == FINISH);
  assign busy = (state != IDLE) && (state != FINISH);
endmodule
